pht_access_ctrl: RTL and testbench
==================================

// Module: pht_access_ctrl
// PURPOSE
//  Controller for the branch pattern-history table (PHT), an array of 2-bit saturating counters.
//  Shares the table's single access port between two requesters:
//    - IF-stage prediction lookups.
//    - EX-stage training updates.
//  Training updates are held in a 1-entry buffer. The controller sweeps the table to a known state after reset or flush.
//  Sits between IF/EX and the counter array. Owns the array, the init sequence and the arbitration.
// PARAMETERS
//  IDX_W       6      index width; table depth = 2**IDX_W
//  PC_W        32     PC width; index = pc[IDX_W+1:2]
//  INIT_CNT    2'b01  counter value written by the init sweep (weakly not-taken)
//  STARVE_LIM  4      cycles a buffered train may wait before it preempts prediction
// PORTS
//  clk_i           in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  flush_i         in   1     synchronous request to re-run the init sweep
//  pred_req_i      in   1     IF requests a prediction
//  pred_pc_i       in   PC_W  PC to predict
//  pred_ready_o    out  1     prediction request accepted this cycle if pred_req_i=1
//  pred_valid_o    out  1     1-cycle pulse: pred_taken_o is valid
//  pred_taken_o    out  1     predicted direction (counter bit 1)
//  train_valid_i   in   1     EX presents a resolved branch
//  train_pc_i      in   PC_W  PC of resolved branch
//  train_taken_i   in   1     actual direction
//  train_ready_o   out  1     train accepted this cycle if train_valid_i=1
//  init_done_o     out  1     table initialised, controller in RUN
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - Outputs: all 0.
//   - state=INIT, sweep_ptr=0, buf_valid=0, age=0.
//   - Array is not reset; its contents are undefined until the sweep completes.
//  INIT:
//   - Each cycle: table[sweep_ptr] <= INIT_CNT, then sweep_ptr++.
//   - pred_ready_o=0, train_ready_o=0, init_done_o=0.
//   - After writing index 2**IDX_W-1 -> RUN. The sweep takes exactly 2**IDX_W cycles.
//  RUN: init_done_o=1. The table sees at most one access per cycle.
//   - drain        = buf_valid && (age>=STARVE_LIM || !pred_req_i)
//   - pred_ready_o = !(buf_valid && age>=STARVE_LIM)
//   - train_ready_o = !buf_valid || drain. Does not depend on train_valid_i, so there is no comb loop.
//   - Predict accept (pred_req_i && pred_ready_o):
//       - Reads table[idx(pred_pc_i)].
//       - Next cycle: pred_valid_o=1, pred_taken_o = counter[1].
//       - Latency is 1 cycle. Back-to-back accepts give back-to-back pulses.
//   - Forwarding: if buf_valid and buf_idx==idx(pred_pc_i), the read value is sat(table[buf_idx], buf_taken).
//       - A train accepted in the same cycle is NOT forwarded.
//   - Drain: table[buf_idx] <= sat(table[buf_idx], buf_taken). buf_valid clears unless refilled.
//   - sat(): SNT 00 <-> WNT 01 <-> WT 10 <-> ST 11.
//       - taken increments; not-taken decrements.
//       - Saturates at 11 and at 00; no wrap.
//   - Train accept loads buffer {idx, taken}. buf_valid=1, age=0.
//       - Accept and drain may occur in the same cycle: the old entry is written, the new one is loaded.
//   - age: increments (saturating at STARVE_LIM) each cycle buf_valid && !drain; cleared on drain or load.
//   - Idle cycle (no request, buffer empty): no table access, no output change except pred_valid_o=0.
//  flush_i (any state):
//   - Next state INIT, sweep_ptr=0, buf_valid=0 (pending train dropped), age=0.
//   - No pred_valid_o pulse is issued for a request accepted in the flush cycle.
//   - flush_i during INIT restarts the sweep from 0.
//  Async reset mid-sweep or mid-drain: immediate return to reset values. Any partial write is discarded.
// TESTING
//  1 Reset release, IDX_W=6:
//     - init_done_o rises exactly 64 cycles later.
//     - All 64 entries predict not-taken (pred_taken_o=0).
//  2 Train pc=0x40 taken twice with pred_req_i=0: both drain immediately.
//     - Predict pc=0x40 -> pred_valid_o next cycle, pred_taken_o=1 (counter 11).
//     - A third taken train leaves the counter at 11 (saturation).
//  3 Train pc=0x40 not-taken x4 from 11:
//     - Counter reaches 00 and stays.
//     - Predicts 1,0,0,0 after each step.
//  4 Continuous pred_req_i=1 with one buffered train:
//     - pred_ready_o=0 on exactly the 5th cycle (age=4); the drain happens then.
//     - train_ready_o=1 that cycle.
//  5 Buffered taken train pc=0x80 (counter 01), then predict pc=0x80 before the drain -> pred_taken_o=1 (forwarded).
//  6 flush_i with a pending train:
//     - Buffer dropped; the sweep reruns for 64 cycles.
//     - The trained entry reads INIT_CNT afterward.

Source files
------------

// File: rtl/pht_access_ctrl.sv
// Branch pattern-history table controller: owns the 2-bit counter array, runs the
// init sweep after reset/flush, and arbitrates IF lookups against buffered EX training.
module pht_access_ctrl #(
   parameter int unsigned IDX_W      = 6,
   parameter int unsigned PC_W       = 32,
   parameter logic [1:0]  INIT_CNT   = 2'b01,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic            clk_i,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            pred_req_i,
   input  logic [PC_W-1:0] pred_pc_i,
   output logic            pred_ready_o,
   output logic            pred_valid_o,
   output logic            pred_taken_o,
   input  logic            train_valid_i,
   input  logic [PC_W-1:0] train_pc_i,
   input  logic            train_taken_i,
   output logic            train_ready_o,
   output logic            init_done_o
);

   localparam int unsigned DEPTH = 2**IDX_W;
   localparam int unsigned AGE_W = $clog2(STARVE_LIM + 1);
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic             buf_valid_q, buf_valid_d;
   logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
   logic             buf_taken_q, buf_taken_d;
   logic [AGE_W-1:0] age_q, age_d;
   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;

   logic [1:0]       mem_q [DEPTH];
   logic             tbl_we;
   logic [IDX_W-1:0] tbl_widx;
   logic [1:0]       tbl_wdata;

   logic [IDX_W-1:0] pred_idx, train_idx;
   logic             in_run, starve, drain;
   logic             pred_acc, train_acc;
   logic [1:0]       rd_raw, rd_val, drain_val;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0],
                             train_pc_i[PC_W-1:IDX_W+2], train_pc_i[1:0]};

   function automatic logic [1:0] sat2(input logic [1:0] c, input logic taken);
      if (taken) return (c == 2'b11) ? 2'b11 : c + 2'b01;
      else       return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   assign pred_idx  = pred_pc_i[IDX_W+1:2];
   assign train_idx = train_pc_i[IDX_W+1:2];

   assign in_run = (state_q == ST_RUN);
   assign starve = buf_valid_q && (age_q >= AGE_LIM);
   assign drain  = in_run && buf_valid_q && (starve || !pred_req_i);

   assign pred_ready_o  = in_run && !starve;
   assign train_ready_o = in_run && (!buf_valid_q || drain);
   assign init_done_o   = in_run;
   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;

   assign pred_acc  = pred_req_i && pred_ready_o;
   assign train_acc = train_valid_i && train_ready_o;

   // A lookup hitting the buffered entry sees the counter as if the train had drained.
   assign rd_raw    = mem_q[pred_idx];
   assign drain_val = sat2(mem_q[buf_idx_q], buf_taken_q);
   assign rd_val    = (buf_valid_q && (buf_idx_q == pred_idx)) ? sat2(rd_raw, buf_taken_q) : rd_raw;

   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      buf_valid_d  = buf_valid_q;
      buf_idx_d    = buf_idx_q;
      buf_taken_d  = buf_taken_q;
      age_d        = age_q;
      pred_valid_d = 1'b0;
      pred_taken_d = pred_taken_q;
      tbl_we       = 1'b0;
      tbl_widx     = buf_idx_q;
      tbl_wdata    = drain_val;

      case (state_q)
         ST_INIT: begin
            tbl_we    = 1'b1;
            tbl_widx  = sweep_q;
            tbl_wdata = INIT_CNT;
            sweep_d   = sweep_q + IDX_W'(1);
            if (sweep_q == {IDX_W{1'b1}}) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (pred_acc) begin
               pred_valid_d = 1'b1;
               pred_taken_d = rd_val[1];
            end
            if (drain) tbl_we = 1'b1;
            if (train_acc) begin
               buf_valid_d = 1'b1;
               buf_idx_d   = train_idx;
               buf_taken_d = train_taken_i;
               age_d       = '0;
            end else if (drain) begin
               buf_valid_d = 1'b0;
               age_d       = '0;
            end else if (buf_valid_q && (age_q != AGE_LIM)) begin
               age_d = age_q + AGE_W'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase

      // Flush overrides everything: the sweep reruns, so any write this cycle is moot.
      if (flush_i) begin
         state_d      = ST_INIT;
         sweep_d      = '0;
         buf_valid_d  = 1'b0;
         age_d        = '0;
         pred_valid_d = 1'b0;
         pred_taken_d = pred_taken_q;
         tbl_we       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         sweep_q      <= '0;
         buf_valid_q  <= 1'b0;
         buf_idx_q    <= '0;
         buf_taken_q  <= 1'b0;
         age_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         buf_valid_q  <= buf_valid_d;
         buf_idx_q    <= buf_idx_d;
         buf_taken_q  <= buf_taken_d;
         age_q        <= age_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
      end
   end

   // Counter array is intentionally not reset; the sweep defines its contents.
   always_ff @(posedge clk_i) begin
      if (tbl_we && rst_n) mem_q[tbl_widx] <= tbl_wdata;
   end

endmodule

// File: tb/tb_pht_access_ctrl.sv
// Randomized scoreboard bench for pht_access_ctrl against a transaction-level PHT model.
module tb_pht_access_ctrl;

   localparam int IDX_W = 6;
   localparam int PC_W  = 32;
   localparam int DEPTH = 64;
   localparam int LIM   = 4;

   logic            clk_i = 1'b0;
   logic            rst_n = 1'b1;
   logic            flush_i = 1'b0;
   logic            pred_req_i = 1'b0;
   logic [PC_W-1:0] pred_pc_i = '0;
   logic            pred_ready_o, pred_valid_o, pred_taken_o;
   logic            train_valid_i = 1'b0;
   logic [PC_W-1:0] train_pc_i = '0;
   logic            train_taken_i = 1'b0;
   logic            train_ready_o, init_done_o;

   always #5 clk_i = ~clk_i;

   pht_access_ctrl #(
      .IDX_W(IDX_W), .PC_W(PC_W), .INIT_CNT(2'b01), .STARVE_LIM(LIM)
   ) dut (
      .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
      .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
      .pred_ready_o(pred_ready_o), .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
      .train_valid_i(train_valid_i), .train_pc_i(train_pc_i), .train_taken_i(train_taken_i),
      .train_ready_o(train_ready_o), .init_done_o(init_done_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit exp_q[$];

   // Reference model: counter values, one pending train, and sweep progress.
   int cnt[DEPTH];
   bit m_run;
   int m_init_cyc;
   bit m_bv;
   int m_bidx;
   bit m_bt;
   int m_age;
   int cyc_since_rst;
   int first_done_cyc;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int sat(input int c, input bit t);
      if (t) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   always @(negedge clk_i) begin
      if (rst_n && pred_valid_o) begin
         bit e;
         if (exp_q.size() == 0) begin
            chk("unexpected_pred_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("pred_taken", int'(pred_taken_o), int'(e));
         end
      end
   end

   // Called at posedge+1; inputs held for the whole cycle.
   task automatic step(input bit preq, input logic [31:0] ppc, input bit tv,
                       input logic [31:0] tpc, input bit tt, input bit fl);
      bit starve, drain, e_pr, e_tr, pacc, tacc;
      int pidx, tidx, v;
      flush_i = fl; pred_req_i = preq; pred_pc_i = ppc;
      train_valid_i = tv; train_pc_i = tpc; train_taken_i = tt;
      #3;
      pidx = int'(ppc[7:2]);
      tidx = int'(tpc[7:2]);
      starve = 0; drain = 0; e_pr = 0; e_tr = 0;
      if (m_run) begin
         starve = m_bv && (m_age >= LIM);
         drain  = m_bv && (starve || !preq);
         e_pr   = !starve;
         e_tr   = !m_bv || drain;
      end
      chk("init_done", int'(init_done_o), int'(m_run));
      chk("pred_ready", int'(pred_ready_o), int'(e_pr));
      chk("train_ready", int'(train_ready_o), int'(e_tr));
      pacc = preq && e_pr;
      tacc = tv && e_tr;
      if (pacc && !fl) begin
         v = cnt[pidx];
         if (m_bv && m_bidx == pidx) v = sat(v, m_bt);
         exp_q.push_back(v >= 2);
      end
      @(posedge clk_i); #1;
      cyc_since_rst++;
      if (fl) begin
         m_run = 0; m_init_cyc = 0; m_bv = 0; m_age = 0;
      end else if (!m_run) begin
         m_init_cyc++;
         if (m_init_cyc == DEPTH) begin
            m_run = 1;
            foreach (cnt[i]) cnt[i] = 1;
         end
      end else begin
         if (drain) cnt[m_bidx] = sat(cnt[m_bidx], m_bt);
         if (tacc) begin
            m_bv = 1; m_bidx = tidx; m_bt = tt; m_age = 0;
         end else if (drain) begin
            m_bv = 0; m_age = 0;
         end else if (m_bv && m_age < LIM) begin
            m_age++;
         end
      end
      if (init_done_o && first_done_cyc < 0) first_done_cyc = cyc_since_rst;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush_i = 0; pred_req_i = 0; train_valid_i = 0; train_taken_i = 0;
      #2;
      chk("rst_pred_valid", int'(pred_valid_o), 0);
      chk("rst_pred_taken", int'(pred_taken_o), 0);
      chk("rst_pred_ready", int'(pred_ready_o), 0);
      chk("rst_train_ready", int'(train_ready_o), 0);
      chk("rst_init_done", int'(init_done_o), 0);
      exp_q.delete();
      m_run = 0; m_init_cyc = 0; m_bv = 0; m_age = 0;
      cyc_since_rst = 0; first_done_cyc = -1;
      @(posedge clk_i); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] pc, tpc;
      #2;
      rst_n = 1'b0;
      @(posedge clk_i); #1;
      do_reset();
      idle(70);
      chk("init_latency", first_done_cyc, 64);

      for (int i = 0; i < DEPTH; i++) step(1, 32'(i) << 2, 0, 0, 0, 0);
      idle(2);

      // Taken twice then a saturating third taken at pc 0x40.
      step(0, 0, 1, 32'h40, 1, 0);
      step(0, 0, 1, 32'h40, 1, 0);
      idle(1);
      step(1, 32'h40, 0, 0, 0, 0);
      step(0, 0, 1, 32'h40, 1, 0);
      idle(1);
      step(1, 32'h40, 0, 0, 0, 0);
      idle(1);

      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 32'h40, 0, 0);
         idle(1);
         step(1, 32'h40, 0, 0, 0, 0);
         idle(1);
      end

      // One buffered train under continuous prediction traffic: starvation preempt.
      step(1, 32'h4, 1, 32'h100, 1, 0);
      for (int i = 0; i < 7; i++) step(1, 32'(i) << 2, 0, 0, 0, 0);
      idle(2);

      // Forwarding from the buffer.
      step(0, 0, 1, 32'h80, 1, 0);
      step(1, 32'h80, 0, 0, 0, 0);
      idle(2);
      step(1, 32'h80, 0, 0, 0, 0);
      idle(1);

      // Flush with a pending train at pc 0xC0 after it reached 11.
      step(0, 0, 1, 32'hC0, 1, 0);
      step(0, 0, 1, 32'hC0, 1, 0);
      idle(1);
      step(1, 32'hC0, 1, 32'hC0, 1, 0);
      step(1, 32'hC0, 0, 0, 0, 0);
      step(1, 32'hC0, 0, 0, 0, 1);
      idle(20);
      step(0, 0, 0, 0, 0, 1);
      idle(66);
      step(1, 32'hC0, 0, 0, 0, 0);
      idle(1);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            idle(30);
            do_reset();
            idle(66);
         end
         pc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         tpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1, tpc,
              $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
      end
      idle(3);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
